// File: rtl/uart_fifo.sv
// uart_fifo: buffered UART, TX/RX engines each fronted by a show-ahead FIFO,
// 16x oversampled receiver with start-glitch reject and sticky error flags.
// Optional feature macro: UART_PARITY_EN (even parity bit after the data bits).
module uart_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 re,
  input  logic                 clr_err,
  input  logic                 rxd,
  output logic                 txd,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);
  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW      = $clog2(DATA_BITS);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PW      = AW + 1;
  localparam int TX      = 0;
  localparam int RX      = 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  // ---------------- oversample tick ----------------
  logic [DW-1:0] div_q, div_d;
  logic          tick;

  always_comb begin
    tick  = (div_q == DW'(DIV - 1));
    div_d = tick ? '0 : div_q + DW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_q <= '0;
    else        div_q <= div_d;
  end

  // ---------------- FIFOs (0 = TX, 1 = RX) ----------------
  logic [1:0]                f_push, f_pop, f_full, f_valid;
  logic [1:0][DATA_BITS-1:0] f_din, f_dout;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
    logic                 valid_q, valid_d, full, do_push, do_pop;
    logic [DATA_BITS-1:0] head_q, head_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    // Head register is loaded from next-state pointers so a pop shows the
    // following entry immediately; a push into the head slot bypasses memory.
    always_comb begin
      full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      do_pop  = f_pop[g] && valid_q;
      do_push = f_push[g] && (!full || do_pop);
      wr_d    = wr_q + PW'(do_push);
      rd_d    = rd_q + PW'(do_pop);
      valid_d = (wr_d != rd_d);
      head_d  = mem_q[rd_d[AW-1:0]];
      if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0])) head_d = f_din[g];
    end

    always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= f_din[g];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_q    <= '0;
        rd_q    <= '0;
        valid_q <= 1'b0;
        head_q  <= '0;
      end else begin
        wr_q    <= wr_d;
        rd_q    <= rd_d;
        valid_q <= valid_d;
        head_q  <= head_d;
      end
    end

    assign f_full[g]  = full;
    assign f_valid[g] = valid_q;
    assign f_dout[g]  = head_q;
  end

  // ---------------- TX engine ----------------
  state_e               tx_state_q;
  logic [3:0]           tx_cnt_q;
  logic [BW-1:0]        tx_bit_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 txd_q;
  logic                 tx_pop, tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  // Popping at the last tick of STOP chains frames with no idle gap.
  always_comb begin
    tx_bit_end = tick && (tx_cnt_q == 4'd15);
    tx_pop     = tick && f_valid[TX] &&
                 ((tx_state_q == S_IDLE) || ((tx_state_q == S_STOP) && (tx_cnt_q == 4'd15)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      if (tick) tx_cnt_q <= tx_cnt_q + 4'd1;
      case (tx_state_q)
        S_IDLE: begin
          tx_cnt_q <= '0;
          txd_q    <= 1'b1;
        end
        S_START: if (tx_bit_end) begin
          tx_state_q <= S_DATA;
          txd_q      <= tx_sh_q[0];
          tx_sh_q    <= tx_sh_q >> 1;
          tx_bit_q   <= '0;
        end
        S_DATA: if (tx_bit_end) begin
          if (tx_bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            tx_state_q <= S_PAR;
            txd_q      <= tx_par_q;
`else
            tx_state_q <= S_STOP;
            txd_q      <= 1'b1;
`endif
          end else begin
            tx_bit_q <= tx_bit_q + BW'(1);
            txd_q    <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
          end
        end
`ifdef UART_PARITY_EN
        S_PAR: if (tx_bit_end) begin
          tx_state_q <= S_STOP;
          txd_q      <= 1'b1;
        end
`endif
        S_STOP: if (tx_bit_end) tx_state_q <= S_IDLE;
        default: tx_state_q <= S_IDLE;
      endcase
      if (tx_pop) begin
        tx_state_q <= S_START;
        txd_q      <= 1'b0;
        tx_sh_q    <= f_dout[TX];
`ifdef UART_PARITY_EN
        tx_par_q   <= ^f_dout[TX];
`endif
      end
    end
  end

  // ---------------- RX engine ----------------
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  state_e               rx_state_q;
  logic [3:0]           rx_cnt_q;
  logic [BW-1:0]        rx_bit_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 rx_push_q, rx_ferr_q, rx_bit_end;
`ifdef UART_PARITY_EN
  logic                 rx_par_bad_q, rx_perr_q;
`endif

  assign rx_bit_end = tick && (rx_cnt_q == 4'd15);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_push_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= 1'b0;
      rx_perr_q    <= 1'b0;
`endif
    end else begin
      rx_push_q <= 1'b0;
      if (tick) rx_cnt_q <= rx_cnt_q + 4'd1;
      case (rx_state_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_s2_q) rx_state_q <= S_START;
        end
        // Half-bit check of the start bit; realigns the counter to bit centres.
        S_START: if (tick && (rx_cnt_q == 4'd7)) begin
          rx_cnt_q <= '0;
          if (rx_s2_q) rx_state_q <= S_IDLE;
          else begin
            rx_state_q <= S_DATA;
            rx_bit_q   <= '0;
          end
        end
        S_DATA: if (rx_bit_end) begin
          rx_sh_q <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            rx_state_q <= S_PAR;
`else
            rx_state_q <= S_STOP;
`endif
          end else begin
            rx_bit_q <= rx_bit_q + BW'(1);
          end
        end
`ifdef UART_PARITY_EN
        S_PAR: if (rx_bit_end) begin
          rx_par_bad_q <= rx_s2_q ^ (^rx_sh_q);
          rx_state_q   <= S_STOP;
        end
`endif
        S_STOP: if (rx_bit_end) begin
          rx_push_q  <= 1'b1;
          rx_ferr_q  <= !rx_s2_q;
`ifdef UART_PARITY_EN
          rx_perr_q  <= rx_par_bad_q;
`endif
          rx_state_q <= S_IDLE;
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- FIFO hookup and sticky flags ----------------
  assign f_push = {rx_push_q, we};
  assign f_pop  = {re, tx_pop};
  assign f_din  = {rx_sh_q, tx_data};

  logic frame_err_q, frame_err_d, overrun_q, overrun_d, rx_drop;
`ifdef UART_PARITY_EN
  logic parity_err_q, parity_err_d;
`endif

  // Set has priority over a simultaneous clear.
  always_comb begin
    rx_drop     = rx_push_q && f_full[RX] && !(re && f_valid[RX]);
    frame_err_d = (frame_err_q && !clr_err) || (rx_push_q && rx_ferr_q);
    overrun_d   = (overrun_q && !clr_err) || rx_drop;
`ifdef UART_PARITY_EN
    parity_err_d = (parity_err_q && !clr_err) || (rx_push_q && rx_perr_q);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign txd       = txd_q;
  assign tx_full   = f_full[TX];
  assign tx_busy   = f_valid[TX] || (tx_state_q != S_IDLE);
  assign rx_data   = f_dout[RX];
  assign rx_valid  = f_valid[RX];
  assign rx_busy   = (rx_state_q != S_IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: 16 clk per bit, FIFO_DEPTH=4, serial
// frames built and decoded from the frame format with a queue scoreboard.
module tb_uart_fifo;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic          clk = 1'b0, reset = 1'b0, we = 1'b0, re = 1'b0, clr_err = 1'b0;
  logic          rxd_drv = 1'b1, loop_en = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          rxd_w, txd, tx_full, tx_busy, rx_valid, rx_busy;
  logic          frame_err, overrun, parity_err;
  logic [DB-1:0] rx_data;
  int            n_checks = 0, n_fail = 0, cyc = 0;

  assign rxd_w = loop_en ? txd : rxd_drv;

  uart_fifo #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .we(we), .tx_data(tx_data), .re(re), .clr_err(clr_err),
    .rxd(rxd_w), .txd(txd), .tx_full(tx_full), .tx_busy(tx_busy), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tx_write(input logic [DB-1:0] d);
    tx_data = d;
    we      = 1'b1;
    @(negedge clk);
    we      = 1'b0;
  endtask

  // Drive one serial frame on rxd: start, LSB-first data, [parity], stop.
  task automatic send_rx(input logic [DB-1:0] d, input logic stop_v);
    rxd_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rxd_drv = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rxd_drv = ^d;
    repeat (16) @(negedge clk);
`endif
    rxd_drv = stop_v;
    repeat (16) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_rx(input string name, input logic [DB-1:0] exp);
    check({name, "_valid"}, rx_valid, 1);
    check(name, rx_data, exp);
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
  endtask

  // Decode one frame from txd, sampling at bit centres; returns at stop centre.
  task automatic decode_tx(output logic [DB-1:0] b, output int t_fall, output bit ok);
    int k;
    k = 0; ok = 0; b = '0; t_fall = 0;
    while (txd !== 1'b0 && k < 64 * NB) begin
      @(negedge clk);
      k++;
    end
    if (txd !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL tx_frame_timeout: txd=%b after %0d cycles, expected a start bit", txd, k);
      return;
    end
    ok = 1;
    t_fall = cyc;
    repeat (8) @(negedge clk);
    check("tx_start_bit", txd, 0);
    for (int i = 0; i < DB; i++) begin
      repeat (16) @(negedge clk);
      b[i] = txd;
    end
`ifdef UART_PARITY_EN
    repeat (16) @(negedge clk);
    check("tx_parity_bit", txd, ^b);
`endif
    repeat (16) @(negedge clk);
    check("tx_stop_bit", txd, 1);
  endtask

  task automatic wait_tx_idle(input string name);
    int k;
    k = 0;
    while (tx_busy !== 1'b0 && k < 64 * NB * 6) begin
      @(negedge clk);
      k++;
    end
    check(name, tx_busy, 0);
  endtask

  typedef struct packed {
    logic [DB-1:0] din;
    logic          stop;
    logic [DB-1:0] exp_data;
    logic          exp_ferr;
  } rx_vec_t;

  rx_vec_t       vt [4];
  logic [DB-1:0] bq [$];
  logic [DB-1:0] burst [6];
  int            tf [5];
  logic [DB-1:0] b;
  int            t0, t1;
  bit            ok, seen;

  initial begin
    vt[0] = '{din: 8'h3C, stop: 1'b1, exp_data: 8'h3C, exp_ferr: 1'b0};
    vt[1] = '{din: 8'h55, stop: 1'b0, exp_data: 8'h55, exp_ferr: 1'b1};
    vt[2] = '{din: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0};
    vt[3] = '{din: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_busy", rx_busy, 0);
    check("rst_flags", {frame_err, overrun, parity_err}, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // single frame 0xA5 and write-to-start latency
    t0 = cyc;
    tx_write(8'hA5);
    decode_tx(b, t1, ok);
    if (ok) begin
      check("tx_A5_data", b, 8'hA5);
      check("tx_latency_le_18", (t1 - t0) <= 18, 1);
    end
    repeat (20) @(negedge clk);

    // burst: 5 accepted (one in flight + DEPTH queued), 6th dropped while full
    for (int i = 0; i < 6; i++) burst[i] = DB'($urandom);
    fork
      begin
        for (int i = 0; i < 5; i++) tx_write(burst[i]);
        check("tx_full_after_burst", tx_full, 1);
        tx_write(burst[5]);
      end
      begin
        logic [DB-1:0] db;
        bit            dok;
        for (int j = 0; j < 5; j++) begin
          decode_tx(db, tf[j], dok);
          if (dok) check("tx_burst_data", db, burst[j]);
        end
      end
    join
    check("tx_busy_last_stop", tx_busy, 1);
    for (int j = 1; j < 5; j++) check("tx_back_to_back_gap", tf[j] - tf[j-1], 16 * NB);
    repeat (9) @(negedge clk);
    check("tx_busy_after_burst", tx_busy, 0);
    repeat (40) @(negedge clk);
    check("tx_dropped_write_line_idle", txd, 1);

    // RX table
    for (int i = 0; i < 4; i++) begin
      send_rx(vt[i].din, vt[i].stop);
      check("rx_tbl_ferr", frame_err, vt[i].exp_ferr);
      pop_rx("rx_tbl_data", vt[i].exp_data);
      check("rx_tbl_empty_after_re", rx_valid, 0);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("rx_tbl_ferr_cleared", frame_err, 0);
    end

    // start-bit glitch rejected
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rx_busy) seen = 1;
      @(negedge clk);
    end
    check("glitch_rx_busy_seen", seen, 1);
    repeat (20) @(negedge clk);
    check("glitch_rx_busy_idle", rx_busy, 0);
    check("glitch_no_push", rx_valid, 0);
    check("glitch_no_flags", {frame_err, overrun}, 0);

    // frame error set beats a held clr_err
    clr_err = 1'b1;
    fork
      send_rx(8'h55, 1'b0);
      begin
        seen = 0;
        for (int i = 0; i < NB * 16 + 8; i++) begin
          @(negedge clk);
          if (frame_err) seen = 1;
        end
      end
    join
    check("ferr_set_beats_clr", seen, 1);
    check("ferr_cleared_by_held_clr", frame_err, 0);
    clr_err = 1'b0;
    pop_rx("ferr_byte_pushed", 8'h55);

    // loopback
    loop_en = 1'b1;
    repeat (4) @(negedge clk);
    tx_write(8'h3C);
    wait_tx_idle("loop_tx_idle");
    repeat (4) @(negedge clk);
    pop_rx("loop_3C", 8'h3C);
    check("loop_valid_after_re", rx_valid, 0);

    for (int i = 0; i < DEPTH; i++) begin
      b = DB'($urandom);
      bq.push_back(b);
      tx_write(b);
    end
    wait_tx_idle("loop_burst_idle");
    repeat (4) @(negedge clk);
    while (bq.size() > 0) pop_rx("loop_rand", bq.pop_front());
    check("loop_rand_empty", rx_valid, 0);
    check("loop_rand_no_overrun", overrun, 0);
    loop_en = 1'b0;
    repeat (4) @(negedge clk);

    // overrun: DEPTH+1 frames with no re
    for (int i = 0; i <= DEPTH; i++) begin
      b = DB'($urandom);
      if (i < DEPTH) bq.push_back(b);
      send_rx(b, 1'b1);
    end
    check("ovr_set", overrun, 1);
    check("ovr_no_ferr", frame_err, 0);
    while (bq.size() > 0) pop_rx("ovr_kept", bq.pop_front());
    check("ovr_empty", rx_valid, 0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("ovr_cleared", overrun, 0);

    // async reset mid-frame
    tx_write(8'h00);
    repeat (40) @(negedge clk);
    check("midframe_txd_low", txd, 0);
    #2 reset = 1'b0;
    #1;
    check("midframe_rst_txd", txd, 1);
    check("midframe_rst_busy", tx_busy, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("after_rst_txd_idle", txd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
